imm_extend_pipe: RTL and testbench
==================================

// Module: imm_extend_pipe
// PURPOSE
//   Pipelined, parametrised immediate extender for the datapath decode/execute boundary.
//   Converts an IN_W-bit immediate to OUT_W bits in one of four modes:
//   sign, zero, upper-load, and sign with a left shift of 2 for branch offsets.
//   Registered valid/ready stream with a 2-entry skid buffer: 1 result/cycle, full throughput under backpressure.
// PARAMETERS
//   IN_W   16  immediate input width
//   OUT_W  32  result width; elaboration error if OUT_W < IN_W+2
//   TAG_W   5  sideband tag width (e.g. destination register); carried unchanged with each result
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   in_valid   in   1      input transfer request
//   in_ready   out  1      block can accept; = !skid_valid && !reset
//   in_imm     in   IN_W   immediate
//   in_mode    in   2      00 SIGN, 01 ZERO, 10 UPPER, 11 SIGN_SHL2
//   in_tag     in   TAG_W  sideband tag
//   out_valid  out  1      result available
//   out_ready  in   1      consumer accepts result
//   out_data   out  OUT_W  extended result
//   out_tag    out  TAG_W  tag of out_data
//   xfer_cnt   out  16     output transfer count (present only with IMM_EXT_CNT_EN)
// BEHAVIOUR
// - Reset (sync, high): out_valid=0, out_data=0, out_tag=0, skid empty, xfer_cnt=0; in_ready=0 while reset is high.
//   Reset mid-operation discards the output and skid entries.
// - Accept: in_valid && in_ready at a clock edge. Output transfer: out_valid && out_ready at a clock edge.
// - Arithmetic, with i = in_imm:
//   SIGN = {(OUT_W-IN_W){i[IN_W-1]}, i}
//   ZERO = {(OUT_W-IN_W){1'b0}, i}
//   UPPER = i << (OUT_W-IN_W); bits beyond OUT_W are dropped
//   SIGN_SHL2 = SIGN << 2, truncated to OUT_W
// - Latency: result visible on out_* the cycle after acceptance if the output register is free or draining.
// - Output register (OR) update each edge:
//   - OR empty or out transfer, skid full: OR <- skid; skid <- accepted item, if any.
//   - OR empty or out transfer, skid empty: OR <- accepted item, if any; otherwise out_valid <- 0.
//   - OR full and no out transfer: accepted item -> skid; OR holds stable (data/tag must not change while out_valid && !out_ready).
// - in_ready is a function of registered skid state only; no combinational in->out ready path.
// - Ordering is strictly FIFO. No loss or duplication under any valid/ready pattern.
// - in_valid with in_ready=0: the source must hold its item; the block ignores it.
// CONFIGURATION
// - IMM_EXT_CNT_EN defined:
//   - xfer_cnt port exists; increments by 1 on each output transfer.
//   - Wraps 0xFFFF->0x0000. Cleared by reset.
// - IMM_EXT_CNT_EN undefined: port and counter absent. All other behaviour is identical.
// STRUCTURE
// - Shared package imm_ext_pkg: mode localparams MODE_SIGN/MODE_ZERO/MODE_UPPER/MODE_SHL2 (2-bit), and the stream entry layout {tag, data}.
// - Sub-module imm_ext_core: purely combinational (imm, mode) -> data, parametrised IN_W/OUT_W.
// - The top level holds the output register, the skid register, handshake logic and the optional counter.
// TESTING  (IN_W=16, OUT_W=32, TAG_W=5)
// 1. SIGN:
//    - 0x8001 tag 3 -> 0xFFFF8001 tag 3, one cycle after accept.
//    - 0x7FFF -> 0x00007FFF.
// 2. ZERO 0x8001 -> 0x00008001. UPPER 0x1234 -> 0x12340000.
// 3. SIGN_SHL2: 0xFFFF -> 0xFFFFFFFC; 0x0004 -> 0x00000010; 0x8000 -> 0xFFFE0000.
// 4. Stream tags 1..8, every cycle, out_ready=1 -> 8 results on consecutive cycles; in_ready stays 1.
// 5. Stream tags 1,2,3 with out_ready=0 for 4 cycles:
//    - tag1 held stable on out_*; tag2 in skid; in_ready=0 from the edge after tag2 is accepted; tag3 waits.
//    - Release -> 1,2,3 in order.
// 6. Reset with skid full:
//    - Next cycle out_valid=0; in_ready=1 after reset drops; xfer_cnt=0.
//    - With IMM_EXT_CNT_EN, 65537 transfers -> xfer_cnt=1.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate extender: mode encodings.
// Stream entries are packed as {tag, data}, with data in the low bits.
package imm_ext_pkg;

    localparam logic [1:0] MODE_SIGN  = 2'b00;
    localparam logic [1:0] MODE_ZERO  = 2'b01;
    localparam logic [1:0] MODE_UPPER = 2'b10;
    localparam logic [1:0] MODE_SHL2  = 2'b11;

    localparam int CNT_W = 16;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: (imm, mode) -> OUT_W-bit result.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] data
);

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;

    assign sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    assign zext = {{(OUT_W-IN_W){1'b0}}, imm};

    always_comb begin
        data = sext;
        unique case (mode)
            MODE_SIGN:  data = sext;
            MODE_ZERO:  data = zext;
            MODE_UPPER: data = zext << (OUT_W-IN_W);
            MODE_SHL2:  data = sext << 2;
            default:    data = sext;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender with output register and one-entry skid.
// Optional output transfer counter enabled by defining IMM_EXT_CNT_EN.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
`ifdef IMM_EXT_CNT_EN
    ,
    output logic [CNT_W-1:0] xfer_cnt
`endif
);

    // SHL2 needs two spare bits above the immediate to stay meaningful.
    if (OUT_W < IN_W + 2) begin : g_width_check
        $error("imm_extend_pipe: OUT_W must be at least IN_W+2");
    end

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [OUT_W-1:0] data;
    } entry_t;

    entry_t           in_ent;
    entry_t           or_q;
    entry_t           skid_q;
    logic             or_valid;
    logic             skid_valid;
    logic             accept;
    logic             or_free;
    logic [OUT_W-1:0] ext_data;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm  (in_imm),
        .mode (in_mode),
        .data (ext_data)
    );

    assign in_ent    = '{tag: in_tag, data: ext_data};
    assign in_ready  = !skid_valid && !reset;
    assign accept    = in_valid && in_ready;
    assign or_free   = !or_valid || out_ready;

    assign out_valid = or_valid;
    assign out_data  = or_q.data;
    assign out_tag   = or_q.tag;

    // The skid only fills while the output register is stalled, so a full
    // skid implies no accept this cycle and it drains before new input.
    always_ff @(posedge clk) begin
        if (reset) begin
            or_valid   <= 1'b0;
            or_q       <= '0;
            skid_valid <= 1'b0;
            skid_q     <= '0;
        end else if (or_free) begin
            if (skid_valid) begin
                or_q       <= skid_q;
                or_valid   <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                or_valid <= accept;
                if (accept) or_q <= in_ent;
            end
        end else if (accept) begin
            skid_q     <= in_ent;
            skid_valid <= 1'b1;
        end
    end

`ifdef IMM_EXT_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)                      xfer_cnt <= '0;
        else if (or_valid && out_ready) xfer_cnt <= xfer_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed cases plus randomized
// valid/ready traffic against a queue-based reference model.
module tb_imm_extend_pipe;
    import imm_ext_pkg::*;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm = '0;
    logic [1:0]       in_mode = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
`ifdef IMM_EXT_CNT_EN
    logic [15:0]      xfer_cnt;
`endif

    always #5 clk = ~clk;

    imm_extend_pipe #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
`ifdef IMM_EXT_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [OUT_W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   mcnt;
    int   n_cmp;
    int   n_bad;

    // Reference: signed/unsigned integer arithmetic on the immediate value.
    function automatic logic [31:0] ref_ext(input logic [15:0] i, input logic [1:0] m);
        int          s;
        logic [31:0] u;
        s = int'($signed(i));
        u = 32'(i);
        case (m)
            MODE_SIGN:  return 32'(s);
            MODE_ZERO:  return u;
            MODE_UPPER: return u * 32'd65536;
            default:    return 32'(s * 4);
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, obs, expv, $time);
        end
    endtask

    // One clock cycle: drive, check against the model mid-cycle, advance model.
    task automatic tick(input logic iv, input logic [15:0] imm, input logic [1:0] md,
                        input logic [4:0] tg, input logic ordy, output bit acc);
        bit xf;
        exp_t e;
        in_valid  = iv;
        in_imm    = imm;
        in_mode   = md;
        in_tag    = tg;
        out_ready = ordy;
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
        if (out_valid && exp_q.size() != 0) begin
            chk("out_data", 64'(out_data), 64'(exp_q[0].data));
            chk("out_tag", 64'(out_tag), 64'(exp_q[0].tag));
        end
`ifdef IMM_EXT_CNT_EN
        chk("xfer_cnt", 64'(xfer_cnt), 64'(mcnt % 65536));
`endif
        acc = iv && in_ready;
        xf  = out_valid && ordy;
        @(posedge clk);
        #1;
        if (xf && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            mcnt++;
        end
        if (acc) begin
            e.tag  = tg;
            e.data = ref_ext(imm, md);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset(input int n);
        reset     = 1'b1;
        in_valid  = 1'($urandom);
        out_ready = 1'($urandom);
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_out_data", 64'(out_data), 64'd0);
            chk("rst_out_tag", 64'(out_tag), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd0);
`ifdef IMM_EXT_CNT_EN
            chk("rst_xfer_cnt", 64'(xfer_cnt), 64'd0);
`endif
        end
        exp_q.delete();
        mcnt     = 0;
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_rel_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic const_case(input string name, input logic [15:0] imm, input logic [1:0] md,
                              input logic [4:0] tg, input logic [31:0] expd);
        bit a;
        tick(1'b1, imm, md, tg, 1'b1, a);
        chk({name, "_acc"}, 64'(a), 64'd1);
        chk(name, 64'(out_data), 64'(expd));
        chk({name, "_tag"}, 64'(out_tag), 64'(tg));
        tick(1'b0, '0, '0, '0, 1'b1, a);
    endtask

    initial begin
        bit          a;
        bit          have;
        logic [15:0] p_imm;
        logic [1:0]  p_md;
        logic [4:0]  p_tg;
        int          guard;

        n_cmp = 0;
        n_bad = 0;
        mcnt  = 0;
        do_reset(3);

        const_case("sign_neg",  16'h8001, MODE_SIGN,  5'd3, 32'hFFFF8001);
        const_case("sign_pos",  16'h7FFF, MODE_SIGN,  5'd4, 32'h00007FFF);
        const_case("zero",      16'h8001, MODE_ZERO,  5'd5, 32'h00008001);
        const_case("upper",     16'h1234, MODE_UPPER, 5'd6, 32'h12340000);
        const_case("shl2_m1",   16'hFFFF, MODE_SHL2,  5'd7, 32'hFFFFFFFC);
        const_case("shl2_4",    16'h0004, MODE_SHL2,  5'd8, 32'h00000010);
        const_case("shl2_min",  16'h8000, MODE_SHL2,  5'd9, 32'hFFFE0000);

        // Back-to-back stream, no backpressure.
        for (int t = 1; t <= 8; t++) begin
            tick(1'b1, 16'($urandom), 2'($urandom), 5'(t), 1'b1, a);
            chk("stream_acc", 64'(a), 64'd1);
        end
        repeat (2) tick(1'b0, '0, '0, '0, 1'b1, a);

        // Backpressure: tag1 in output, tag2 in skid, tag3 held off.
        tick(1'b1, 16'h1111, MODE_SIGN, 5'd1, 1'b0, a);
        chk("bp_acc1", 64'(a), 64'd1);
        tick(1'b1, 16'h2222, MODE_ZERO, 5'd2, 1'b0, a);
        chk("bp_acc2", 64'(a), 64'd1);
        repeat (2) begin
            tick(1'b1, 16'h3333, MODE_UPPER, 5'd3, 1'b0, a);
            chk("bp_hold3", 64'(a), 64'd0);
            chk("bp_tag1_stable", 64'(out_tag), 64'd1);
        end
        a = 1'b0;
        guard = 0;
        while (!a && guard < 10) begin
            tick(1'b1, 16'h3333, MODE_UPPER, 5'd3, 1'b1, a);
            guard++;
        end
        chk("bp_acc3", 64'(a), 64'd1);
        repeat (4) tick(1'b0, '0, '0, '0, 1'b1, a);

        // Reset with the skid full.
        tick(1'b1, 16'hAAAA, MODE_SIGN, 5'd10, 1'b0, a);
        tick(1'b1, 16'hBBBB, MODE_SIGN, 5'd11, 1'b0, a);
        chk("skid_full_in_ready", 64'(in_ready), 64'd0);
        do_reset(1);

        // Randomized traffic; the source holds an item until it is accepted.
        have = 1'b0;
        p_imm = '0; p_md = '0; p_tg = '0;
        for (int c = 0; c < 2000; c++) begin
            if (!have && ($urandom % 4) != 0) begin
                have  = 1'b1;
                p_imm = 16'($urandom);
                p_md  = 2'($urandom);
                p_tg  = 5'($urandom);
            end
            tick(have, p_imm, p_md, p_tg, 1'(($urandom % 3) != 0), a);
            if (a) have = 1'b0;
            if (($urandom % 500) == 0) begin
                do_reset(1 + int'($urandom % 2));
                have = 1'b0;
            end
        end
        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            tick(1'b0, '0, '0, '0, 1'b1, a);
            guard++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

`ifdef IMM_EXT_CNT_EN
        do_reset(1);
        guard = 0;
        while (mcnt < 65537 && guard < 70000) begin
            tick(1'b1, 16'($urandom), 2'($urandom), 5'($urandom), 1'b1, a);
            guard++;
        end
        chk("cnt_reached", 64'(mcnt), 64'd65537);
        chk("cnt_wrap", 64'(xfer_cnt), 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
